// File: rtl/y86_pkg.sv
// Shared definitions for the Y86 SEQ memory stage: instruction codes, the
// memory-stage FSM states and the operand-select encodings used by the decoder.
package y86_pkg;

  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  localparam int WORD_BYTES = 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} mem_state_t;

  typedef enum logic {ADDR_VALE = 1'b0, ADDR_VALA = 1'b1} addr_sel_t;
  typedef enum logic {DATA_VALA = 1'b0, DATA_VALP = 1'b1} data_sel_t;

endpackage

// File: rtl/mem_op_decode.sv
// Combinational decode of icode into the memory operation: whether an access
// is needed, its direction, and which execute outputs feed address and data.
module mem_op_decode
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic       needs_mem,
  output logic       we,
  output logic       addr_sel,
  output logic       data_sel
);

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    needs_mem = 1'b0;
    we        = 1'b0;
    addr_sel  = ADDR_VALE;
    data_sel  = DATA_VALA;
    unique case (icode)
      ICODE_RMMOVQ: begin needs_mem = 1'b1; we = 1'b1; end
      ICODE_MRMOVQ: needs_mem = 1'b1;
      ICODE_CALL:   begin needs_mem = 1'b1; we = 1'b1; data_sel = DATA_VALP; end
      ICODE_RET:    begin needs_mem = 1'b1; addr_sel = ADDR_VALA; end
      ICODE_PUSHQ:  begin needs_mem = 1'b1; we = 1'b1; end
      ICODE_POPQ:   begin needs_mem = 1'b1; addr_sel = ADDR_VALA; end
      default:      needs_mem = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Requester side of the SEQ memory stage: decodes the access, checks the
// address, and runs a valid/ready request plus response handshake with timeout.
module mem_access_ctrl
  import y86_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int MEM_WORDS = 8192,
  parameter int TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        icode,
  input  logic [ADDR_W-1:0] valE,
  input  logic [DATA_W-1:0] valA,
  input  logic [DATA_W-1:0] valP,
  output logic [DATA_W-1:0] valM,
  output logic              memerror,
  output logic              mem_done,
  output logic              stall,
  output logic              mreq_valid,
  output logic              mreq_we,
  output logic [ADDR_W-1:0] mreq_addr,
  output logic [DATA_W-1:0] mreq_wdata,
  input  logic              mreq_ready,
  input  logic              mrsp_valid,
  input  logic [DATA_W-1:0] mrsp_rdata,
  input  logic              mrsp_err
);

  localparam int                CNT_W      = $clog2(TIMEOUT + 1);
  localparam int                ALIGN_W    = $clog2(WORD_BYTES);
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_WORDS * WORD_BYTES);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(TIMEOUT);

  mem_state_t        state, state_next;
  logic              needs_mem, dec_we, addr_sel, data_sel;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              addr_bad, access_ok, timeout_hit;
  logic [CNT_W-1:0]  tmo_cnt;

  mem_op_decode u_decode (
    .icode     (icode),
    .needs_mem (needs_mem),
    .we        (dec_we),
    .addr_sel  (addr_sel),
    .data_sel  (data_sel)
  );

  always_comb begin
    req_addr  = (addr_sel == ADDR_VALA) ? ADDR_W'(valA) : valE;
    req_wdata = (data_sel == DATA_VALP) ? valP : valA;
    addr_bad  = (req_addr >= ADDR_LIMIT) || (req_addr[ALIGN_W-1:0] != '0);
    access_ok = needs_mem && !addr_bad;
  end

  // The last WAIT cycle is the TIMEOUT-th; a response on that cycle still wins.
  assign timeout_hit = (tmo_cnt >= CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = access_ok ? REQ : DONE;
      REQ:  if (mreq_ready) state_next = WAIT;
      WAIT: if (mrsp_valid || timeout_hit) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mreq_valid = (state == REQ);
    mem_done   = (state == DONE);
    stall      = ((state == IDLE) && start) || (state == REQ) || (state == WAIT);
  end

  // Request fields are captured once in IDLE so they stay stable through REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mreq_we    <= 1'b0;
      mreq_addr  <= '0;
      mreq_wdata <= '0;
      valM       <= '0;
      memerror   <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          if (access_ok) begin
            mreq_we    <= dec_we;
            mreq_addr  <= req_addr;
            mreq_wdata <= req_wdata;
            memerror   <= 1'b0;
          end else begin
            memerror   <= needs_mem;
          end
        end
        REQ: if (mreq_ready) tmo_cnt <= '0;
        WAIT: begin
          if (mrsp_valid) begin
            memerror <= mrsp_err;
            if (!mreq_we && !mrsp_err) valM <= mrsp_rdata;
          end else if (timeout_hit) begin
            memerror <= 1'b1;
          end
          if (tmo_cnt != CNT_MAX) tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a transaction-level timeline model
// predicts every cycle's outputs while the bench plays the memory responder.
module tb_mem_access_ctrl;

  localparam int ADDR_W    = 64;
  localparam int DATA_W    = 64;
  localparam int MEM_WORDS = 8192;
  localparam int TIMEOUT   = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [3:0]        icode;
  logic [ADDR_W-1:0] valE;
  logic [DATA_W-1:0] valA, valP, valM;
  logic              memerror, mem_done, stall;
  logic              mreq_valid, mreq_we;
  logic [ADDR_W-1:0] mreq_addr;
  logic [DATA_W-1:0] mreq_wdata;
  logic              mreq_ready, mrsp_valid, mrsp_err;
  logic [DATA_W-1:0] mrsp_rdata;

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .icode(icode),
    .valE(valE), .valA(valA), .valP(valP), .valM(valM),
    .memerror(memerror), .mem_done(mem_done), .stall(stall),
    .mreq_valid(mreq_valid), .mreq_we(mreq_we), .mreq_addr(mreq_addr),
    .mreq_wdata(mreq_wdata), .mreq_ready(mreq_ready), .mrsp_valid(mrsp_valid),
    .mrsp_rdata(mrsp_rdata), .mrsp_err(mrsp_err)
  );

  typedef struct {
    bit          active;
    bit          valid;
    bit          stall;
    bit          done;
    bit          we;
    bit          err;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] valm;
  } exp_t;

  exp_t        exp_c;
  logic [63:0] mdl_valm;
  int          tests = 0;
  int          fails = 0;
  int          cyc;
  int          done_cyc;
  bit          done_err;
  int          valid_cnt;
  bit          seen_we;
  logic [63:0] seen_addr, seen_wdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
    end
  endtask

  // Single compare process: checks the DUT against the model mid-cycle.
  initial forever begin
    @(negedge clk);
    if (exp_c.active) begin
      check("mreq_valid", mreq_valid, exp_c.valid);
      check("stall", stall, exp_c.stall);
      check("mem_done", mem_done, exp_c.done);
      check("valM", valM, exp_c.valm);
      if (exp_c.valid) begin
        check("mreq_we", mreq_we, exp_c.we);
        check("mreq_addr", mreq_addr, exp_c.addr);
        check("mreq_wdata", mreq_wdata, exp_c.wdata);
      end
      if (exp_c.done) check("memerror", memerror, exp_c.err);
    end
    if (mem_done) begin
      done_cyc = cyc;
      done_err = memerror;
    end
    if (mreq_valid) begin
      valid_cnt++;
      seen_we    = mreq_we;
      seen_addr  = mreq_addr;
      seen_wdata = mreq_wdata;
    end
  end

  function automatic logic nz(input bit en);
    return en ? 1'($urandom_range(0, 1)) : 1'b0;
  endfunction

  function automatic void model_decode(input logic [3:0] ic, input logic [63:0] ve, va, vp,
                                       output bit need, output bit we,
                                       output logic [63:0] addr, output logic [63:0] wdata);
    need = 1'b1; we = 1'b0; addr = ve; wdata = va;
    case (ic)
      4'h4: we = 1'b1;
      4'h5: ;
      4'h8: begin we = 1'b1; wdata = vp; end
      4'h9: addr = va;
      4'hA: we = 1'b1;
      4'hB: addr = va;
      default: need = 1'b0;
    endcase
  endfunction

  task automatic tick(input exp_t e);
    exp_c = e;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic junk_rsp();
    mrsp_rdata = {$urandom, $urandom};
    mrsp_err   = 1'($urandom_range(0, 1));
  endtask

  task automatic idle_cycle();
    exp_t e;
    start = 1'b0; mreq_ready = nz(1); mrsp_valid = nz(1); junk_rsp();
    e = '{active: 1, valid: 0, stall: 0, done: 0, we: 0, err: 0,
          addr: 0, wdata: 0, valm: mdl_valm};
    tick(e);
  endtask

  // One access: r = REQ cycles before ready, d = WAIT cycle of the response
  // (d >= TIMEOUT means the response never arrives).
  task automatic run_txn(input logic [3:0] ic, input logic [63:0] ve, va, vp,
                         input int r, input int d, input logic [63:0] rd,
                         input bit err, input bit noise);
    bit          need, we, bad, exp_err;
    logic [63:0] addr, wdata;
    int          n_wait;
    exp_t        e;
    model_decode(ic, ve, va, vp, need, we, addr, wdata);
    bad = need && ((addr >= 64'(MEM_WORDS * 8)) || (addr[2:0] != 3'b000));
    icode = ic; valE = ve; valA = va; valP = vp;
    cyc = 0; done_cyc = -1; valid_cnt = 0;
    start = 1'b1; mreq_ready = nz(noise); mrsp_valid = nz(noise); junk_rsp();
    e = '{active: 1, valid: 0, stall: 1, done: 0, we: we, err: 0,
          addr: addr, wdata: wdata, valm: mdl_valm};
    tick(e);
    if (!need || bad) begin
      start = nz(noise); mreq_ready = nz(noise); mrsp_valid = nz(noise);
      e.stall = 0; e.done = 1; e.err = bad;
      tick(e);
    end else begin
      for (int k = 0; k <= r; k++) begin
        start = nz(noise); mreq_ready = (k == r); mrsp_valid = nz(noise); junk_rsp();
        e.valid = 1; e.stall = 1;
        tick(e);
      end
      n_wait = (d < TIMEOUT) ? d + 1 : TIMEOUT;
      for (int k = 0; k < n_wait; k++) begin
        start = nz(noise); mreq_ready = nz(noise);
        mrsp_valid = (k == d);
        if (k == d) begin mrsp_rdata = rd; mrsp_err = err; end
        else junk_rsp();
        e.valid = 0; e.stall = 1;
        tick(e);
      end
      if (d < TIMEOUT) begin
        exp_err = err;
        if (!we && !err) mdl_valm = rd;
      end else begin
        exp_err = 1'b1;
      end
      start = nz(noise); mreq_ready = nz(noise); mrsp_valid = nz(noise); junk_rsp();
      e.stall = 0; e.done = 1; e.err = exp_err; e.valm = mdl_valm;
      tick(e);
    end
    start = 1'b0; mreq_ready = 1'b0; mrsp_valid = 1'b0;
  endtask

  function automatic logic [63:0] gen_addr();
    logic [63:0] a;
    a = 64'($urandom_range(0, MEM_WORDS - 1)) << 3;
    case ($urandom_range(0, 11))
      0: a = a + 64'($urandom_range(1, 7));
      1: a = a + 64'(MEM_WORDS * 8);
      2: a = {$urandom, $urandom};
      default: ;
    endcase
    return a;
  endfunction

  initial begin
    logic [3:0] mem_ops [6];
    logic [3:0] ic;
    int         r, d;
    mem_ops = '{4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    exp_c = '{active: 0, valid: 0, stall: 0, done: 0, we: 0, err: 0,
              addr: 0, wdata: 0, valm: 0};
    mdl_valm = '0; cyc = 0;
    rst_n = 1'b0; start = 1'b0; icode = 4'h0; valE = '0; valA = '0; valP = '0;
    mreq_ready = 1'b0; mrsp_valid = 1'b0; mrsp_rdata = '0; mrsp_err = 1'b0;

    #12;
    check("reset valM", valM, 64'h0);
    check("reset memerror", memerror, 1'b0);
    check("reset mem_done", mem_done, 1'b0);
    check("reset stall", stall, 1'b0);
    check("reset mreq_valid", mreq_valid, 1'b0);
    check("reset mreq_addr", mreq_addr, 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: rmmovq, immediate ready and response.
    run_txn(4'h4, 64'h100, 64'hDEAD, 64'h0, 0, 0, 64'h0, 1'b0, 1'b0);
    check("t1 done cycle", 64'(done_cyc), 64'd3);
    check("t1 we", seen_we, 1'b1);
    check("t1 addr", seen_addr, 64'h100);
    check("t1 wdata", seen_wdata, 64'hDEAD);
    check("t1 memerror", done_err, 1'b0);

    // 2: popq, slow ready then slow response.
    run_txn(4'hB, 64'h0, 64'h40, 64'h0, 3, 2, 64'h55, 1'b0, 1'b0);
    check("t2 valM", valM, 64'h55);
    check("t2 done cycle", 64'(done_cyc), 64'd8);
    check("t2 valid cycles", 64'(valid_cnt), 64'd4);
    check("t2 addr", seen_addr, 64'h40);

    // 3: address boundaries.
    run_txn(4'h5, 64'h10000, 64'h0, 64'h0, 0, 0, 64'h0, 1'b0, 1'b0);
    check("t3 done cycle", 64'(done_cyc), 64'd1);
    check("t3 memerror", done_err, 1'b1);
    check("t3 no request", 64'(valid_cnt), 64'd0);
    run_txn(4'h4, 64'h104, 64'h1, 64'h0, 0, 0, 64'h0, 1'b0, 1'b0);
    check("t3 misaligned err", done_err, 1'b1);
    run_txn(4'h5, 64'hFFF8, 64'h0, 64'h0, 0, 0, 64'h77, 1'b0, 1'b0);
    check("t3 last word valM", valM, 64'h77);

    // 4: ret with no response, start noise during WAIT; then response on last WAIT cycle.
    run_txn(4'h9, 64'h0, 64'h80, 64'h0, 0, TIMEOUT, 64'h0, 1'b0, 1'b1);
    check("t4 done cycle", 64'(done_cyc), 64'(2 + TIMEOUT));
    check("t4 memerror", done_err, 1'b1);
    run_txn(4'h9, 64'h0, 64'h88, 64'h0, 0, TIMEOUT - 1, 64'h99, 1'b0, 1'b0);
    check("t4 late rsp err", done_err, 1'b0);
    check("t4 late rsp valM", valM, 64'h99);

    // 5: OPq does no access and leaves valM alone.
    run_txn(4'h6, 64'h8, 64'h8, 64'h0, 0, 0, 64'h0, 1'b0, 1'b0);
    check("t5 done cycle", 64'(done_cyc), 64'd1);
    check("t5 valM kept", valM, 64'h99);
    check("t5 memerror", done_err, 1'b0);

    // 6: reset while in WAIT.
    exp_c.active = 0;
    icode = 4'h9; valA = 64'h80; start = 1'b1; mreq_ready = 1'b0; mrsp_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; mreq_ready = 1'b1;
    @(posedge clk); #1;
    mreq_ready = 1'b0;
    check("t6 stall in wait", stall, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6 mreq_valid", mreq_valid, 1'b0);
    check("t6 stall", stall, 1'b0);
    check("t6 valM", valM, 64'h0);
    check("t6 mreq_addr", mreq_addr, 64'h0);
    @(posedge clk); #1;
    check("t6 held valid", mreq_valid, 1'b0);
    rst_n = 1'b1;
    mdl_valm = '0;
    run_txn(4'h5, 64'h200, 64'h0, 64'h0, 1, 1, 64'h1234, 1'b0, 1'b0);
    check("t6 recover valM", valM, 64'h1234);
    check("t6 recover done", 64'(done_cyc), 64'd5);

    // Randomized traffic with noise on every ignored input.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) ic = 4'($urandom_range(0, 15));
      else ic = mem_ops[$urandom_range(0, 5)];
      r = $urandom_range(0, 3);
      d = ($urandom_range(0, 5) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 2)
                                      : $urandom_range(0, 4);
      run_txn(ic, gen_addr(), gen_addr(), {$urandom, $urandom}, r, d,
              {$urandom, $urandom}, ($urandom_range(0, 4) == 0), 1'b1);
      for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle();
    end

    exp_c.active = 0;
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
